// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - RV32I control decode carried through a stall/flush/freeze-aware pipe with halt drain.
// Define CTRL_PIPE_PERF_CNT_EN to add the bubble_cnt and retire_cnt outputs.
module ctrl_pipe_unit #(
  parameter int NUM_STAGES   = 3,
  parameter int FLUSH_STAGES = 1,
  parameter int OPCODE_W     = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [OPCODE_W-1:0]     opcode,
  input  logic                    id_valid,
  input  logic                    halt_cond,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    mem_busy,
  output logic [NUM_STAGES*12-1:0] ctrl_out,
  output logic                    is_halted,
  output logic                    drain_active
`ifdef CTRL_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]             bubble_cnt,
  output logic [31:0]             retire_cnt
`endif
);

  localparam int B_JAL    = 0;
  localparam int B_JALR   = 1;
  localparam int B_BRANCH = 2;
  localparam int B_MEMRD  = 3;
  localparam int B_M2R    = 4;
  localparam int B_MEMWR  = 5;
  localparam int B_ALUSRC = 6;
  localparam int B_WE     = 7;
  localparam int B_PC2REG = 8;
  localparam int B_ECALL  = 9;
  localparam int B_HALT   = 10;
  localparam int B_VALID  = 11;

  localparam logic [OPCODE_W-1:0] OP_ARITH     = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ARITH_IMM = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD      = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE     = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_JAL       = OPCODE_W'(7'b1101111);
  localparam logic [OPCODE_W-1:0] OP_JALR      = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_BRANCH    = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_ECALL     = OPCODE_W'(7'b1110011);

  localparam int CNT_W = $clog2(NUM_STAGES) + 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] drain_cnt;
  logic [11:0]      dec;
  logic             known;
  logic [11:0]      stg_q [NUM_STAGES];
  logic [11:0]      stg_d [NUM_STAGES];
  logic             ecall_live;

  always_comb begin
    dec   = '0;
    known = 1'b1;
    case (opcode)
      OP_ARITH:     dec[B_WE] = 1'b1;
      OP_ARITH_IMM: begin dec[B_ALUSRC] = 1'b1; dec[B_WE] = 1'b1; end
      OP_LOAD:      begin dec[B_MEMRD] = 1'b1; dec[B_M2R] = 1'b1; dec[B_ALUSRC] = 1'b1; dec[B_WE] = 1'b1; end
      OP_STORE:     begin dec[B_MEMWR] = 1'b1; dec[B_ALUSRC] = 1'b1; end
      OP_JAL:       begin dec[B_JAL] = 1'b1; dec[B_WE] = 1'b1; dec[B_PC2REG] = 1'b1; end
      OP_JALR:      begin dec[B_JALR] = 1'b1; dec[B_ALUSRC] = 1'b1; dec[B_WE] = 1'b1; dec[B_PC2REG] = 1'b1; end
      OP_BRANCH:    dec[B_BRANCH] = 1'b1;
      OP_ECALL:     begin dec[B_ECALL] = 1'b1; dec[B_HALT] = halt_cond; end
      default:      known = 1'b0;
    endcase
    dec[B_VALID] = known & id_valid;
  end

  // Freeze holds everything; flush is applied last so it beats both shift and decode.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) stg_d[k] = stg_q[k];
    if (!mem_busy) begin
      for (int k = 1; k < NUM_STAGES; k++) stg_d[k] = stg_q[k-1];
      stg_d[0] = (stall || !id_valid || state_q != ST_RUN) ? 12'h000 : dec;
      if (flush) begin
        for (int k = 0; k < FLUSH_STAGES; k++) stg_d[k] = 12'h000;
      end
    end
  end

  // The draining ECALL sits at stage NUM_STAGES-drain_cnt after this edge.
  always_comb begin
    ecall_live = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (k == NUM_STAGES - int'(drain_cnt))
        ecall_live = stg_d[k][B_VALID] & stg_d[k][B_HALT];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_STAGES; k++) stg_q[k] <= 12'h000;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      drain_cnt    <= '0;
      drain_active <= 1'b0;
      is_halted    <= 1'b0;
    end else if (!mem_busy) begin
      case (state_q)
        ST_RUN: begin
          if (stg_d[0][B_VALID] && stg_d[0][B_HALT]) begin
            state_q      <= ST_DRAIN;
            drain_cnt    <= CNT_W'(NUM_STAGES - 1);
            drain_active <= 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - CNT_W'(1);
          if (!ecall_live) begin
            state_q      <= ST_RUN;
            drain_cnt    <= '0;
            drain_active <= 1'b0;
          end else if (drain_cnt == CNT_W'(1)) begin
            state_q      <= ST_HALTED;
            drain_active <= 1'b0;
            is_halted    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
    assign ctrl_out[12*g +: 12] = stg_q[g];
  end

`ifdef CTRL_PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else if (!mem_busy && state_q != ST_HALTED) begin
      if (stall || flush) bubble_cnt <= bubble_cnt + 32'd1;
      if (stg_q[NUM_STAGES-1][B_VALID]) retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - Directed and random checks of ctrl_pipe_unit against a stage-list reference model.
module tb_ctrl_pipe_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  opcode;
  logic        id_valid, halt_cond, stall, flush, mem_busy;
  logic [35:0] co_a;
  logic [47:0] co_b;
  logic        halt_a, halt_b, drain_a, drain_b;
`ifdef CTRL_PIPE_PERF_CNT_EN
  logic [31:0] bub_a, bub_b, ret_a, ret_b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.NUM_STAGES(3), .FLUSH_STAGES(1), .OPCODE_W(7)) dut_a (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .id_valid(id_valid),
    .halt_cond(halt_cond), .stall(stall), .flush(flush), .mem_busy(mem_busy),
    .ctrl_out(co_a), .is_halted(halt_a), .drain_active(drain_a)
`ifdef CTRL_PIPE_PERF_CNT_EN
    , .bubble_cnt(bub_a), .retire_cnt(ret_a)
`endif
  );

  ctrl_pipe_unit #(.NUM_STAGES(4), .FLUSH_STAGES(2), .OPCODE_W(7)) dut_b (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .id_valid(id_valid),
    .halt_cond(halt_cond), .stall(stall), .flush(flush), .mem_busy(mem_busy),
    .ctrl_out(co_b), .is_halted(halt_b), .drain_active(drain_b)
`ifdef CTRL_PIPE_PERF_CNT_EN
    , .bubble_cnt(bub_b), .retire_cnt(ret_b)
`endif
  );

  localparam logic [6:0] ARITH = 7'b0110011, ARITH_IMM = 7'b0010011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, JAL = 7'b1101111, JALR = 7'b1100111,
                         BRANCH = 7'b1100011, ECALL = 7'b1110011;

  // Reference: a list of stage bundles per instance plus the position of a draining ECALL.
  int          ns [2] = '{3, 4};
  int          fs [2] = '{1, 2};
  logic [11:0] mstg [2][8];
  int          mpos [2];
  bit          mhalt [2];
  logic [31:0] mbub [2];
  logic [31:0] mret [2];

  function automatic logic [11:0] ref_bundle(input logic [6:0] op, input logic hc);
    case (op)
      ARITH:     return 12'h880;
      ARITH_IMM: return 12'h8C0;
      LOAD:      return 12'h8D8;
      STORE:     return 12'h860;
      JAL:       return 12'h981;
      JALR:      return 12'h9C2;
      BRANCH:    return 12'h804;
      ECALL:     return hc ? 12'hE00 : 12'hA00;
      default:   return 12'h000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) mstg[i][k] = 12'h000;
      mpos[i] = -1; mhalt[i] = 0; mbub[i] = 0; mret[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int n = ns[i];
    bit accept;
    logic [11:0] b;
    if (mem_busy) return;
    if (!mhalt[i]) begin
      if (stall || flush) mbub[i] = mbub[i] + 1;
      if (mstg[i][n-1][11]) mret[i] = mret[i] + 1;
    end
    accept = id_valid && !stall && !flush && !mhalt[i] && (mpos[i] < 0);
    b = ref_bundle(opcode, halt_cond);
    for (int k = n - 1; k > 0; k--) mstg[i][k] = mstg[i][k-1];
    mstg[i][0] = accept ? b : 12'h000;
    if (flush) for (int k = 0; k < fs[i]; k++) mstg[i][k] = 12'h000;
    if (mpos[i] >= 0) begin
      mpos[i] = mpos[i] + 1;
      if (flush && mpos[i] < fs[i]) mpos[i] = -1;
      else if (mpos[i] == n - 1) begin mhalt[i] = 1; mpos[i] = -1; end
    end else if (accept && b[10]) begin
      mpos[i] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [95:0] e0 = '0;
    logic [95:0] e1 = '0;
    for (int k = 0; k < 3; k++) e0[12*k +: 12] = mstg[0][k];
    for (int k = 0; k < 4; k++) e1[12*k +: 12] = mstg[1][k];
    check({tag, " ctrl_a"}, 96'(co_a), e0);
    check({tag, " ctrl_b"}, 96'(co_b), e1);
    check({tag, " halt_a"}, 96'(halt_a), 96'(mhalt[0]));
    check({tag, " halt_b"}, 96'(halt_b), 96'(mhalt[1]));
    check({tag, " drain_a"}, 96'(drain_a), 96'(mpos[0] >= 0));
    check({tag, " drain_b"}, 96'(drain_b), 96'(mpos[1] >= 0));
`ifdef CTRL_PIPE_PERF_CNT_EN
    check({tag, " bub_a"}, 96'(bub_a), 96'(mbub[0]));
    check({tag, " bub_b"}, 96'(bub_b), 96'(mbub[1]));
    check({tag, " ret_a"}, 96'(ret_a), 96'(mret[0]));
    check({tag, " ret_b"}, 96'(ret_b), 96'(mret[1]));
`endif
  endtask

  task automatic step(input string tag);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [6:0] op, input logic v, input logic hc,
                       input logic st, input logic fl, input logic mb);
    opcode = op; id_valid = v; halt_cond = hc; stall = st; flush = fl; mem_busy = mb;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    check({tag, " all_a_zero"}, 96'(co_a), 96'h0);
    reset_n = 1'b1;
  endtask

  function automatic logic [11:0] sa(input int k);
    return co_a[12*k +: 12];
  endfunction

  function automatic logic [11:0] sb(input int k);
    return co_b[12*k +: 12];
  endfunction

  initial begin
    reset_n = 1'b0;
    drive(7'h00, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all("reset");
    check("reset_ctrl_a", 96'(co_a), 96'h0);
    check("reset_halt_a", 96'(halt_a), 96'h0);
    reset_n = 1'b1;

    drive(LOAD, 1, 0, 0, 0, 0);   step("load");
    check("load_s0", 96'(sa(0)), 96'h8D8);
    drive(7'h00, 0, 0, 0, 0, 0);  step("idle1");
    step("idle2");
    check("load_s2", 96'(sa(2)), 96'h8D8);

    drive(STORE, 1, 0, 1, 0, 0);  step("store_stall");
    check("stall_s0", 96'(sa(0)), 96'h000);
    drive(STORE, 1, 0, 0, 0, 0);  step("store");
    check("store_s0", 96'(sa(0)), 96'h860);

    drive(JAL, 1, 0, 0, 0, 0);    step("jal");
    check("jal_b_s0", 96'(sb(0)), 96'h981);
    drive(ARITH, 1, 0, 0, 1, 0);  step("flush2");
    check("flush2_b_s0", 96'(sb(0)), 96'h000);
    check("flush2_b_s1", 96'(sb(1)), 96'h000);
    check("flush2_b_s2", 96'(sb(2)), 96'h860);

    drive(BRANCH, 1, 0, 0, 0, 0); step("branch");
    drive(7'h00, 0, 0, 0, 0, 0);  step("branch_s1");
    check("branch_s1", 96'(sa(1)), 96'h804);
    drive(ARITH, 1, 0, 1, 0, 1);  step("freeze1");
    drive(ARITH, 1, 0, 0, 1, 1);  step("freeze2");
    drive(ARITH, 1, 0, 1, 1, 1);  step("freeze3");
    check("freeze_s1", 96'(sa(1)), 96'h804);

    drive(ECALL, 1, 1, 0, 0, 0);  step("ecall");
    check("ecall_s0", 96'(sa(0)), 96'hE00);
    check("ecall_drain1", 96'(drain_a), 96'h1);
    drive(ARITH, 1, 0, 0, 0, 0);  step("drain2");
    check("drain2_s0", 96'(sa(0)), 96'h000);
    check("drain2_active", 96'(drain_a), 96'h1);
    step("halted_a");
    check("halted_s2", 96'(sa(2)), 96'hE00);
    check("halted_a", 96'(halt_a), 96'h1);
    check("halted_drain", 96'(drain_a), 96'h0);
    step("halted_b");
    check("halted_arith_s0", 96'(sa(0)), 96'h000);

    do_reset("reset_after_halt");
    drive(ECALL, 1, 1, 0, 0, 0);  step("ecall2");
    drive(ARITH, 1, 0, 0, 0, 0);  step("middrain");
    check("middrain_active", 96'(drain_a), 96'h1);
    reset_n = 1'b0;
    #1;
    check("middrain_rst_ctrl", 96'(co_a), 96'h0);
    check("middrain_rst_drain", 96'(drain_a), 96'h0);
    check("middrain_rst_halt", 96'(halt_a), 96'h0);
    #1;
    model_reset();
    check_all("middrain_rst");
    reset_n = 1'b1;

`ifdef CTRL_PIPE_PERF_CNT_EN
    for (int j = 0; j < 5; j++) begin
      drive(ARITH, 1, 0, 0, 0, 0); step("perf_arith");
    end
    drive(ARITH, 1, 0, 1, 0, 0);   step("perf_stall");
    drive(ARITH, 1, 0, 0, 1, 0);   step("perf_flush");
    for (int j = 0; j < 3; j++) begin
      drive(7'h00, 0, 0, 0, 0, 0); step("perf_idle");
    end
    check("perf_bubble", 96'(bub_a), 96'd2);
    check("perf_retire", 96'(ret_a), 96'd5);
    do_reset("perf_reset");
`endif

    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset($sformatf("rand_rst%0d", it));
      end else begin
        logic [6:0] op;
        case ($urandom_range(0, 8))
          0: op = ARITH;   1: op = ARITH_IMM; 2: op = LOAD;  3: op = STORE;
          4: op = JAL;     5: op = JALR;      6: op = BRANCH; 7: op = ECALL;
          default: op = 7'($urandom);
        endcase
        drive(op, $urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
              $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 6) == 0);
        step($sformatf("rand%0d", it));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Parametrised successor to the combinational opcode decoder in the pipelined RV32I core.
- Decodes the ID-stage opcode into a control bundle and carries that bundle through NUM_STAGES internal pipeline registers (default stages are EX, MEM, WB).
- Applies stall, flush and memory-freeze rules inside the block.
- Contains a halt FSM that drains the pipe after a terminating ECALL and raises a sticky is_halted flag.

Parameters:
- NUM_STAGES, 3, number of control pipeline registers after ID; legal range 2..8.
- FLUSH_STAGES, 1, number of leading stages killed by flush; legal range 1..NUM_STAGES.
- OPCODE_W, 7, opcode width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  ID-stage instruction opcode.
- id_valid  in  1  ID holds a real instruction.
- halt_cond  in  1  ID-stage ECALL terminates the program (x17==10, forwarded value).
- stall  in  1  load-use hazard; insert a bubble into stage 0.
- flush  in  1  branch/jump mispredict.
- mem_busy  in  1  data-cache miss; freeze every stage.
- ctrl_out  out  NUM_STAGES*12  flattened bundles; stage k occupies bits [12k+11:12k].
- is_halted  out  1  sticky halt indication.
- drain_active  out  1  halt FSM is in DRAIN.

Behaviour:
- Bundle bit order: 0 is_jal, 1 is_jalr, 2 is_branch, 3 mem_read, 4 mem_to_reg, 5 mem_write, 6 alu_src, 7 write_enable, 8 pc_to_reg, 9 is_ecall, 10 halt, 11 valid.
- Decode (combinational, into the next value of stage 0):
  - ARITH 0110011: we.
  - ARITH_IMM 0010011: alu_src, we.
  - LOAD 0000011: mem_read, mem_to_reg, alu_src, we.
  - STORE 0100011: mem_write, alu_src.
  - JAL 1101111: is_jal, we, pc_to_reg.
  - JALR 1100111: is_jalr, alu_src, we, pc_to_reg.
  - BRANCH 1100011: is_branch.
  - ECALL 1110011: is_ecall, halt=halt_cond.
  - valid=id_valid for every decoded opcode.
  - Any other opcode: all-zero bundle (bubble).
- Bubble means the all-zero bundle.
- Per posedge, priority order:
  1. mem_busy=1: every stage and the FSM hold; stall and flush are ignored.
  2. Otherwise, stage k (k>=1) takes stage k-1.
  3. Stage 0 takes the decode result, or a bubble if stall, !id_valid, or FSM is not in RUN.
  4. If flush: the next value of every stage k<FLUSH_STAGES is a bubble (flush overrides shifting and decode).
- stall and flush together: the flush rules apply; stage 0 is a bubble either way.
- Latency: an instruction decoded at edge n appears in stage k after edge n+k (no freeze cycles).
- Halt FSM states:
  - RUN: a valid halt bundle written into stage 0 moves the FSM to DRAIN with drain_cnt=NUM_STAGES-1.
  - DRAIN: drain_cnt decrements on each non-frozen edge. At 0, and if stage NUM_STAGES-1 holds valid&halt, go to HALTED. If a flush removed the ECALL before it reached the last stage, return to RUN.
  - HALTED: terminal until reset.
  - The halt bundle must survive to stage NUM_STAGES-1 so older instructions complete.
- drain_active=1 only in DRAIN.
- is_halted=1 only in HALTED. In HALTED, stages continue shifting bubbles when not frozen.
- Reset (async, any cycle, including mid-drain): all stages go to bubble, FSM to RUN, is_halted=0, drain_active=0, counters to 0.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro CTRL_PIPE_PERF_CNT_EN.
- When defined:
  - Adds output bubble_cnt (32 bits): increments on each non-frozen edge where stage 0 receives a bubble caused by stall or flush.
  - Adds output retire_cnt (32 bits): increments on each non-frozen edge where the last stage holds valid=1.
  - Both counters wrap at 2^32 and hold while HALTED.
- When undefined: both ports and their logic are absent.

Test Plan:
- Default params; opcode LOAD, id_valid=1, one edge → stage 0 = 0x8D8 (valid, we, alu_src, mem_to_reg, mem_read). After two more edges, stage 2 = 0x8D8.
- STORE decoded with stall=1 → stage 0 = 0x000. The next cycle, stall=0, STORE → stage 0 = 0x860.
- FLUSH_STAGES=2; JAL in stage 0, ARITH in ID, flush=1 → stages 0 and 1 = 0x000 after the edge; stage 2 keeps the former stage 1 contents.
- mem_busy=1 for 3 cycles with BRANCH in stage 1 → all stages unchanged for 3 edges. stall/flush pulses during that window have no effect.
- ECALL with halt_cond=1 → drain_active=1 for 2 edges, then is_halted=1 once stage 2 = 0xE00. ARITH presented afterwards is not accepted (stage 0 stays 0x000). Asserting reset_n=0 mid-drain instead clears is_halted, drain_active and all stages immediately.
- With CTRL_PIPE_PERF_CNT_EN: 5 ARITH instructions, 1 stall, 1 flush, then 3 more edges → bubble_cnt=2, retire_cnt=5.
